// File: rtl/cache_lru_controller.sv
// rtl/cache_lru_controller.sv - 4-way matrix pseudo-LRU sequencer with refill handshake and bulk flush
// One 16-bit matrix per index; row w (bits [4w+3:4w]) counts the ways that w is more recent than.
module cache_lru_controller #(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic                  req_hit,
  input  logic [1:0]            req_hit_way,
  output logic                  resp_valid,
  output logic [1:0]            resp_way,
  output logic                  resp_miss,
  output logic                  refill_valid,
  input  logic                  refill_ready,
  output logic [INDEX_BITS-1:0] refill_index,
  output logic [1:0]            refill_way,
  input  logic                  refill_done,
  input  logic                  flush,
  output logic                  flush_busy
);

  localparam int N = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, FLUSH} state_t;

  state_t                state;
  logic [15:0]           matrix [N];
  logic [INDEX_BITS-1:0] flush_cnt;
  logic                  accept;
  logic [1:0]            miss_way;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [15:0]           wr_data;

  function automatic logic [15:0] lru_touch(input logic [15:0] m, input logic [1:0] w);
    logic [15:0] r;
    r = m;
    for (int k = 0; k < 4; k++) begin
      r[4*k + int'(w)] = 1'b0;
    end
    r[4*int'(w) +: 4] = ~(4'b0001 << w);
    return r;
  endfunction

  function automatic logic [1:0] row_weight(input logic [3:0] r);
    logic [2:0] s;
    s = {2'b00, r[0]} + {2'b00, r[1]} + {2'b00, r[2]} + {2'b00, r[3]};
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

  // Strict less-than keeps the lowest way on ties, so an all-zero matrix yields way 0.
  function automatic logic [1:0] pick_victim(input logic [15:0] m);
    logic [1:0] best;
    logic [1:0] best_w;
    logic [1:0] w;
    best   = 2'd0;
    best_w = row_weight(m[3:0]);
    for (int k = 1; k < 4; k++) begin
      w = row_weight(m[4*k +: 4]);
      if (w < best_w) begin
        best_w = w;
        best   = 2'(k);
      end
    end
    return best;
  endfunction

  assign req_ready = rst_n && (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign miss_way  = pick_victim(matrix[req_index]);

  // Only one matrix write source can be active at a time, keyed off the state.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    case (state)
      IDLE: begin
        if (accept && req_hit) begin
          wr_en   = 1'b1;
          wr_idx  = req_index;
          wr_data = lru_touch(matrix[req_index], req_hit_way);
        end
      end
      REFILL_WAIT: begin
        if (refill_done) begin
          wr_en   = 1'b1;
          wr_idx  = refill_index;
          wr_data = lru_touch(matrix[refill_index], refill_way);
        end
      end
      FLUSH: begin
        wr_en   = 1'b1;
        wr_idx  = flush_cnt;
        wr_data = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        matrix[k] <= '0;
      end
    end else if (wr_en) begin
      matrix[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_way     <= 2'd0;
      resp_miss    <= 1'b0;
      refill_valid <= 1'b0;
      refill_index <= '0;
      refill_way   <= 2'd0;
      flush_busy   <= 1'b0;
      flush_cnt    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
            flush_cnt  <= '0;
          end else if (accept) begin
            if (req_hit) begin
              resp_valid <= 1'b1;
              resp_way   <= req_hit_way;
              resp_miss  <= 1'b0;
            end else begin
              refill_index <= req_index;
              refill_way   <= miss_way;
              refill_valid <= 1'b1;
              state        <= REFILL_REQ;
            end
          end
        end
        REFILL_REQ: begin
          if (refill_ready) begin
            refill_valid <= 1'b0;
            state        <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (refill_done) begin
            resp_valid <= 1'b1;
            resp_way   <= refill_way;
            resp_miss  <= 1'b1;
            state      <= IDLE;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == INDEX_BITS'(N - 1)) begin
            state      <= IDLE;
            flush_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lru_controller.sv
// tb/tb_cache_lru_controller.sv - randomized scoreboard bench for cache_lru_controller
// Reference model tracks per-way last-access time; victim = lowest never-used way, else oldest.
module tb_cache_lru_controller;

  localparam int IB = 6;
  localparam int N  = 1 << IB;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [IB-1:0] req_index;
  logic          req_hit;
  logic [1:0]    req_hit_way;
  logic          resp_valid;
  logic [1:0]    resp_way;
  logic          resp_miss;
  logic          refill_valid;
  logic          refill_ready;
  logic [IB-1:0] refill_index;
  logic [1:0]    refill_way;
  logic          refill_done;
  logic          flush;
  logic          flush_busy;

  cache_lru_controller #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_hit(req_hit), .req_hit_way(req_hit_way),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_miss(resp_miss),
    .refill_valid(refill_valid), .refill_ready(refill_ready),
    .refill_index(refill_index), .refill_way(refill_way), .refill_done(refill_done),
    .flush(flush), .flush_busy(flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [1:0] way; logic miss;} resp_t;
  typedef struct {logic [IB-1:0] idx; logic [1:0] way;} rf_t;

  resp_t resp_q[$];
  rf_t   rf_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    stamp [N][4];
  int    now_t = 0;
  logic  prev_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_victim(input int idx);
    int best;
    for (int w = 0; w < 4; w++) if (stamp[idx][w] == 0) return w;
    best = 0;
    for (int w = 1; w < 4; w++) if (stamp[idx][w] < stamp[idx][best]) best = w;
    return best;
  endfunction

  function automatic void ref_touch(input int idx, input int w);
    now_t++;
    stamp[idx][w] = now_t;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < N; i++) for (int w = 0; w < 4; w++) stamp[i][w] = 0;
  endfunction

  always @(negedge clk) begin
    resp_t r;
    rf_t   f;
    if (rst_n) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got way=%0d miss=%0d, required no response", resp_way, resp_miss);
        end else begin
          r = resp_q.pop_front();
          check("resp_way", 32'(resp_way), 32'(r.way));
          check("resp_miss", 32'(resp_miss), 32'(r.miss));
        end
      end
      if (refill_valid && !prev_rv) begin
        if (rf_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_refill: got idx=%0d way=%0d, required none", refill_index, refill_way);
        end else begin
          f = rf_q.pop_front();
          check("refill_index", 32'(refill_index), 32'(f.idx));
          check("refill_way", 32'(refill_way), 32'(f.way));
        end
      end
    end
    prev_rv = refill_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int idx, input bit hit, input int hway,
                           input int rdy_dly, input int done_dly, input bit stall_chk);
    int v;
    int guard;
    logic [31:0] iv;
    iv = 32'(idx);
    req_valid   = 1'b1;
    req_index   = iv[IB-1:0];
    req_hit     = hit;
    req_hit_way = 2'(hway);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    v = 0;
    if (hit) begin
      resp_q.push_back('{2'(hway), 1'b0});
      ref_touch(idx, hway);
    end else begin
      v = ref_victim(idx);
      rf_q.push_back('{iv[IB-1:0], 2'(v)});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!hit) begin
      for (int i = 0; i < rdy_dly; i++) begin
        if (stall_chk && i == 2) refill_done = 1'b1;
        @(negedge clk);
        if (stall_chk) begin
          check("stall_refill_valid", 32'(refill_valid), 32'd1);
          check("stall_refill_index", 32'(refill_index), iv & (N - 1));
          check("stall_refill_way", 32'(refill_way), 32'(v));
          check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        refill_done = 1'b0;
      end
      refill_ready = 1'b1;
      @(negedge clk);
      check("refill_valid_at_ready", 32'(refill_valid), 32'd1);
      @(posedge clk);
      #1;
      refill_ready = 1'b0;
      repeat (done_dly) tick();
      refill_done = 1'b1;
      resp_q.push_back('{2'(v), 1'b1});
      ref_touch(idx, v);
      @(posedge clk);
      #1;
      refill_done = 1'b0;
    end
  endtask

  task automatic do_flush();
    int cnt;
    int guard;
    flush = 1'b1;
    @(negedge clk);
    check("req_ready_flush_level", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    ref_clear();
    cnt = 0;
    guard = 0;
    @(negedge clk);
    while (flush_busy && guard < 200) begin
      cnt++;
      check("req_ready_in_flush", 32'(req_ready), 32'd0);
      @(negedge clk);
      guard++;
    end
    check("flush_busy_cycles", 32'(cnt), 32'd64);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_way"}, 32'(resp_way), 32'd0);
    check({tag, "_resp_miss"}, 32'(resp_miss), 32'd0);
    check({tag, "_refill_valid"}, 32'(refill_valid), 32'd0);
    check({tag, "_refill_index"}, 32'(refill_index), 32'd0);
    check({tag, "_refill_way"}, 32'(refill_way), 32'd0);
    check({tag, "_flush_busy"}, 32'(flush_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst_n = 1'b0;
    req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_hit_way = 2'd0;
    refill_ready = 1'b0; refill_done = 1'b0; flush = 1'b0;
    ref_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'd1);
    tick();

    // Misses at index 5: ways 0 then 1
    do_lookup(5, 1'b0, 0, 1, 1, 1'b0);
    do_lookup(5, 1'b0, 0, 0, 2, 1'b0);

    // Back-to-back hits at index 9, then a miss picks the oldest way
    for (int w = 0; w < 4; w++) do_lookup(9, 1'b1, w, 0, 0, 1'b0);
    do_lookup(9, 1'b0, 0, 0, 0, 1'b0);

    // refill_ready held low 5 cycles with a stray refill_done
    do_lookup(12, 1'b0, 0, 5, 1, 1'b1);

    // Populate 0 and 63, flush, then a miss at 63
    do_lookup(0, 1'b1, 0, 0, 0, 1'b0);
    do_lookup(0, 1'b0, 0, 0, 0, 1'b0);
    do_lookup(63, 1'b1, 0, 0, 0, 1'b0);
    do_lookup(63, 1'b1, 3, 0, 0, 1'b0);
    do_flush();
    do_lookup(63, 1'b0, 0, 0, 0, 1'b0);

    // Reset while waiting for refill_done
    do_lookup(20, 1'b1, 0, 0, 0, 1'b0);
    do_lookup(20, 1'b1, 1, 0, 0, 1'b0);
    req_valid = 1'b1; req_index = 6'd20; req_hit = 1'b0;
    @(negedge clk);
    v = ref_victim(20);
    rf_q.push_back('{6'd20, 2'(v)});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    refill_ready = 1'b1;
    tick();
    refill_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrefill");
    ref_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    refill_done = 1'b1;
    tick();
    refill_done = 1'b0;
    repeat (3) tick();
    do_lookup(20, 1'b0, 0, 0, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int idx;
      if ($urandom_range(0, 79) == 0) begin
        do_flush();
      end else begin
        idx = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 5));
        do_lookup(idx, $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      end
    end

    repeat (4) tick();
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("refill_queue_drained", 32'(rf_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_lru_controller.md
Name: cache_lru_controller

Overview:
- Sequences the 4-way pseudo-LRU replacement state for a set-associative cache.
- Stores one 16-bit LRU matrix per cache index.
- On each lookup it either updates the matrix for a hit, or picks a victim way, runs a refill handshake with the memory side, and then updates the matrix.
- Sits between the cache tag-compare stage and the refill engine. It also provides a bulk flush that clears all replacement state.

Parameters:
- INDEX_BITS, 6, width of cache index; number of matrices N = 2^INDEX_BITS.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a lookup.
- req_index  in  INDEX_BITS  cache index of lookup.
- req_hit  in  1  tag compare hit.
- req_hit_way  in  2  hitting way; ignored on miss.
- resp_valid  out  1  single-cycle response pulse; no backpressure.
- resp_way  out  2  way used (hit way or victim).
- resp_miss  out  1  response was a miss/refill.
- refill_valid  out  1  refill request to memory side.
- refill_ready  in  1  memory side accepts refill request.
- refill_index  out  INDEX_BITS  index being refilled.
- refill_way  out  2  victim way being refilled.
- refill_done  in  1  one-cycle pulse: refill data written.
- flush  in  1  clear all LRU state (level, sampled in IDLE).
- flush_busy  out  1  flush walk in progress.

Behaviour:
- Matrix encoding:
  - Row w = bits [4w+3:4w].
  - Access to way w: row w becomes all ones except bit w; bit w of every other row is cleared.
- Victim selection:
  - Way whose row has the fewest ones; popcount saturates at 3.
  - Ties resolve to the lowest way index.
  - All-zero matrix gives way 0.
- Reset (rst_n low, async):
  - All N matrices = 0; state IDLE.
  - req_ready=0 while in reset, then 1 in IDLE.
  - resp_valid=0, resp_way=0, resp_miss=0.
  - refill_valid=0, refill_index=0, refill_way=0, flush_busy=0.
- States: IDLE, REFILL_REQ, REFILL_WAIT, FLUSH.
- IDLE:
  - req_ready = !flush.
  - flush=1 goes to FLUSH; it has priority, and no request is accepted that cycle.
  - Accept on req_valid && req_ready.
- Hit accept:
  - Matrix[req_index] updated with req_hit_way at the accepting edge.
  - Next cycle: resp_valid=1, resp_way=req_hit_way, resp_miss=0. Latency 1.
  - Stay IDLE; back-to-back hits are accepted every cycle.
- Miss accept:
  - Victim computed combinationally from matrix[req_index].
  - Index and victim latched into refill_index/refill_way; go to REFILL_REQ.
- REFILL_REQ:
  - refill_valid=1, req_ready=0.
  - refill_index and refill_way are held stable until refill_ready is sampled high; then go to REFILL_WAIT with refill_valid=0.
- REFILL_WAIT:
  - Wait for refill_done.
  - On refill_done: matrix[refill_index] updated with refill_way.
  - Next cycle: resp_valid=1, resp_way=refill_way, resp_miss=1; state IDLE.
  - Miss latency = 1 + cycles in REFILL_REQ + cycles in REFILL_WAIT.
- refill_done outside REFILL_WAIT: ignored.
- flush outside IDLE: ignored until return to IDLE; an in-flight refill completes first.
- FLUSH:
  - flush_busy=1, req_ready=0.
  - Clears matrix[k] for k = 0..N-1, one index per cycle, wrapping counter from 0.
  - Returns to IDLE after the cycle clearing index N-1 (N cycles total); flush_busy=0 in that IDLE cycle.
- Hit in same cycle as that index's flush/refill: impossible, since req_ready=0 outside IDLE.
- Reset mid-refill or mid-flush:
  - Immediate return to reset values.
  - Outstanding refill abandoned; a subsequent refill_done is ignored.

Test Plan:
- After reset, miss at index 5:
  - refill_valid=1, refill_way=0, refill_index=5.
  - After refill_ready then refill_done: resp_valid pulse with resp_way=0, resp_miss=1.
- Second miss at index 5 → victim way 1.
  - Matrix[5] after it = 0x00D0 | 0x000C = 0x00DC.
- Hits at index 9 to ways 0,1,2,3 on consecutive cycles:
  - Four resp pulses, 1-cycle latency, resp_miss=0, no stall.
  - Matrix[9] = 0x7310; a following miss at index 9 picks way 0.
- refill_ready held low 5 cycles:
  - refill_valid, refill_index and refill_way stay stable.
  - req_ready=0; a refill_done pulse during REFILL_REQ is ignored, no response.
- Populate indices 0 and 63, then flush:
  - flush_busy high exactly 64 cycles, req_ready low throughout.
  - A subsequent miss at index 63 picks way 0.
- Assert rst_n low during REFILL_WAIT:
  - All outputs at reset values.
  - A later refill_done pulse produces no resp_valid; index's matrix reads 0 (next miss → way 0).
